// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sequencer for a small combinational gate under test.
// Walks every input vector, waits for the gate to settle, samples its output,
// compares against the selected reference function, and hands each result
// to a downstream logger over a valid/ready handshake while tallying errors.
module truth_table_sequencer #(
  parameter int unsigned N      = 3,  // gate input width (1..8)
  parameter int unsigned SETTLE = 2,  // cycles between driving vec and sampling dut_s (>=1)
  parameter int unsigned OP     = 0   // 0=AND 1=OR 2=XOR 3=NAND
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] vec,
  input  logic         dut_s,
  output logic         log_valid,
  input  logic         log_ready,
  output logic [N-1:0] log_vec,
  output logic         log_s,
  output logic         log_exp,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_REPORT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   vec_q, vec_d;
  logic           log_valid_q, log_valid_d;
  logic [N-1:0]   log_vec_q, log_vec_d;
  logic           log_s_q, log_s_d;
  logic           log_exp_q, log_exp_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N:0]     err_q, err_d;
  logic [N-1:0]   fev_q, fev_d;
  logic           fevv_q, fevv_d;
  logic           exp_bit;

  // Reference function selected by OP, evaluated on the currently driven vector
  always_comb begin
    case (OP)
      0:       exp_bit = &vec_q;
      1:       exp_bit = |vec_q;
      2:       exp_bit = ^vec_q;
      default: exp_bit = ~&vec_q;
    endcase
  end

  // State and datapath registers; reset clears every output immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      log_valid_q <= 1'b0;
      log_vec_q   <= '0;
      log_s_q     <= 1'b0;
      log_exp_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      fev_q       <= '0;
      fevv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      log_valid_q <= log_valid_d;
      log_vec_q   <= log_vec_d;
      log_s_q     <= log_s_d;
      log_exp_q   <= log_exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fev_q       <= fev_d;
      fevv_q      <= fevv_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts on it
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    log_valid_d = log_valid_q;
    log_vec_d   = log_vec_q;
    log_s_d     = log_s_q;
    log_exp_d   = log_exp_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    fev_d       = fev_q;
    fevv_d      = fevv_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fev_d   = '0;
          fevv_d  = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        cnt_d   = CW'(SETTLE - 1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          log_s_d     = dut_s;
          log_exp_d   = exp_bit;
          log_vec_d   = vec_q;
          log_valid_d = 1'b1;
          if (dut_s != exp_bit) begin
            err_d = err_q + (N+1)'(1);
            if (!fevv_q) begin
              fev_d  = vec_q;
              fevv_d = 1'b1;
            end
          end
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_REPORT: begin
        if (log_valid_q && log_ready) begin
          log_valid_d = 1'b0;
          if (vec_q == '1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + N'(1);
            state_d = S_APPLY;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign vec             = vec_q;
  assign log_valid       = log_valid_q;
  assign log_vec         = log_vec_q;
  assign log_s           = log_s_q;
  assign log_exp         = log_exp_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevv_q;
  assign pass            = done_q & ~|err_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with N=3, SETTLE=2, OP=0 (AND).
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] vec;
  logic       dut_s;
  logic       log_valid;
  logic       log_ready = 1'b1;
  logic [2:0] log_vec;
  logic       log_s;
  logic       log_exp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_err_vec;
  logic       first_err_valid;

  // gate behaviour: 0 = correct AND, 1 = stuck at 0, 2 = NAND
  int mode = 0;
  int n_checks = 0;
  int n_fail = 0;
  int edges;

  assign dut_s = (mode == 0) ? (&vec) : (mode == 1) ? 1'b0 : ~&vec;

  always #5 clk = ~clk;

  truth_table_sequencer #(.N(3), .SETTLE(2), .OP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec), .dut_s(dut_s),
    .log_valid(log_valid), .log_ready(log_ready), .log_vec(log_vec),
    .log_s(log_s), .log_exp(log_exp), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_s(input int idx);
    case (mode)
      0:       return idx == 7;
      1:       return 1'b0;
      default: return idx != 7;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"}, vec, 0);
    check({tag, "_log_valid"}, log_valid, 0);
    check({tag, "_log_vec"}, log_vec, 0);
    check({tag, "_log_s"}, log_s, 0);
    check({tag, "_log_exp"}, log_exp, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err_vec"}, first_err_vec, 0);
    check({tag, "_first_err_valid"}, first_err_valid, 0);
  endtask

  // Start a sweep, check every logged record, optionally stall on one vector
  // or pulse start mid-sweep; returns the edge count from start sample to done.
  task automatic run_sweep(input int hold_vec, input int pulse_vec, output int n_edges);
    int idx = 0;
    int hold_left = 0;
    bit prev_v = 1'b0;
    bit held = 1'b0;
    bit pulsed = 1'b0;
    logic [2:0] hv = '0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_vec", vec, 0);
    check("start_err_cleared", err_count, 0);
    check("start_done_cleared", done, 0);
    check("start_fev_cleared", first_err_valid, 0);
    n_edges = 0;
    while (!done && n_edges < 300) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (start) start = 1'b0;
      if (hold_left > 0) begin
        check("hold_log_valid", log_valid, 1);
        check("hold_log_vec", log_vec, hv);
        check("hold_vec", vec, hv);
        hold_left--;
        if (hold_left == 0) log_ready = 1'b1;
      end
      if (log_valid && !prev_v) begin
        check("rec_vec", log_vec, idx);
        check("rec_exp", log_exp, (idx == 7) ? 1 : 0);
        check("rec_s", log_s, model_s(idx));
        idx++;
        if (int'(log_vec) == hold_vec && !held) begin
          held = 1'b1;
          hold_left = 5;
          hv = log_vec;
          log_ready = 1'b0;
        end
      end
      if (int'(vec) == pulse_vec && busy && !pulsed) begin
        pulsed = 1'b1;
        start = 1'b1;
      end
      prev_v = log_valid;
    end
    log_ready = 1'b1;
    check("sweep_done", done, 1);
    check("record_count", idx, 8);
  endtask

  initial begin
    // reset state
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_vec", vec, 0);
    check("idle_busy", busy, 0);

    // 1: correct AND gate
    mode = 0;
    run_sweep(-1, -1, edges);
    check("t1_edges", edges, 32);
    check("t1_err", err_count, 0);
    check("t1_pass", pass, 1);
    check("t1_fevv", first_err_valid, 0);
    check("t1_vec_final", vec, 7);
    check("t1_busy", busy, 0);

    // 2: gate output stuck at 0
    mode = 1;
    run_sweep(-1, -1, edges);
    check("t2_edges", edges, 32);
    check("t2_err", err_count, 1);
    check("t2_fev", first_err_vec, 7);
    check("t2_fevv", first_err_valid, 1);
    check("t2_pass", pass, 0);

    // 3: NAND gate against AND reference
    mode = 2;
    run_sweep(-1, -1, edges);
    check("t3_edges", edges, 32);
    check("t3_err", err_count, 8);
    check("t3_fev", first_err_vec, 0);
    check("t3_fevv", first_err_valid, 1);
    check("t3_pass", pass, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_done_held", done, 1);
    check("t3_err_held", err_count, 8);
    check("t3_vec_held", vec, 7);

    // 4: logger stalls 5 cycles on vector 011
    mode = 0;
    run_sweep(3, -1, edges);
    check("t4_edges", edges, 37);
    check("t4_pass", pass, 1);

    // 5: start pulsed while busy is ignored
    run_sweep(-1, 2, edges);
    check("t5_edges", edges, 32);
    check("t5_pass", pass, 1);
    check("t5_err", err_count, 0);

    // 6: asynchronous reset mid-sweep
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    while (vec != 3'd5 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("t6_reached_101", vec, 5);
    check("t6_err_before", err_count, 5);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_post_vec", vec, 0);
    check("t6_post_log_valid", log_valid, 0);
    check("t6_post_busy", busy, 0);
    check("t6_post_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
